pipeline_stall_controller: RTL and testbench
============================================

# pipeline_stall_controller

Central sequencer for the 5-stage CPU pipeline. It merges the load-use hazard flag, the EX-stage branch-taken flag and the instruction/data memory busy lines into one consistent set of per-stage register enables and flush (bubble) controls. It tracks one wrong-path fetch still in flight after a taken branch, and keeps saturating stall and flush performance counters. It sits beside the hazard detection unit and drives the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

## Interface
- CNT_WIDTH, 32, width of both performance counters
- CLK  in  1  pipeline clock, all state updates on rising edge
- RESET  in  1  asynchronous, active-low reset
- LU_HAZ_SIG  in  1  load-use hazard from hazard detection unit (ID vs EX)
- BRANCH_TAKEN  in  1  EX-stage branch/jump resolved taken, PC target valid this cycle
- INSTR_MEM_BUSY  in  1  instruction fetch not complete this cycle
- DATA_MEM_BUSY  in  1  data memory access in MEM stage not complete this cycle
- CLEAR_COUNTERS  in  1  synchronous clear of both counters
- PC_EN  out  1  PC register load enable
- IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN  out  1 each  pipeline register load enables
- IF_ID_FLUSH, ID_EX_FLUSH  out  1 each  load NOP into the register on next edge (valid only with that register's EN=1)
- FLUSH_PENDING  out  1  wrong-path fetch outstanding (state visibility)
- STALL_COUNT  out  CNT_WIDTH  cycles with PC_EN=0 (reset excluded)
- FLUSH_COUNT  out  CNT_WIDTH  cycles with IF_ID_FLUSH=1 caused by branch or pending flush

## Operation
- States: RUN, PEND (wrong-path fetch in flight). FLUSH_PENDING=1 exactly in PEND.
- Control outputs are combinational from state and inputs. Defaults: all EN=1, all FLUSH=0. Rules are applied in strict priority:
  1. DATA_MEM_BUSY=1: freeze. All EN=0, FLUSH=0, state held. The branch and hazard inputs are ignored.
  2. BRANCH_TAKEN=1: all EN=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1. LU_HAZ_SIG is ignored because its consumer is squashed.
     - If INSTR_MEM_BUSY=1 in the same cycle, the next state is PEND.
     - Otherwise the state is unchanged.
  3. State PEND with INSTR_MEM_BUSY=1: PC_EN=0, IF_ID_FLUSH=1, others EN=1. Stay in PEND.
  4. State PEND with INSTR_MEM_BUSY=0 (wrong-path word returning): PC_EN=0, IF_ID_FLUSH=1, others EN=1. Next state is RUN. The PC keeps the branch target, so the next fetch is the target.
  5. LU_HAZ_SIG=1: PC_EN=0, IF_ID_EN=0, ID_EX_FLUSH=1, EX_MEM_EN=1, MEM_WB_EN=1.
  6. INSTR_MEM_BUSY=1: PC_EN=0, IF_ID_FLUSH=1, rest advance.
  7. Otherwise: all EN=1, FLUSH=0.
- Counters, registered:
  - STALL_COUNT increments when PC_EN=0.
  - FLUSH_COUNT increments on cycles matched by rules 2, 3 or 4.
  - Both saturate at 2^CNT_WIDTH-1 and never wrap.
  - CLEAR_COUNTERS=1 loads 0 on the edge and overrides any increment that cycle.

## Timing
- Reset (RESET=0, asynchronous):
  - state becomes RUN and the counters become 0 immediately;
  - all EN=0, all FLUSH=0, FLUSH_PENDING=0 while RESET is low;
  - counters do not increment.
- First edge after RESET rises: normal rule evaluation.
- Control outputs have zero-cycle latency from inputs (same cycle). Counters and state update on the following rising edge.
- A load-use hazard produces exactly one bubble cycle when LU_HAZ_SIG drops after one cycle. It is held as long as LU_HAZ_SIG stays high.
- Branch with free fetch: 1 flush cycle. Branch with busy fetch: 1 flush cycle, N cycles in PEND while busy, then 1 final discard cycle.
- DATA_MEM_BUSY inside PEND: frozen and stays PEND. Its cycles count as stalls, not flushes.
- Reset asserted in PEND: return to RUN asynchronously. The pending discard is dropped.

## Test plan
- Reset then idle: RESET=0 → all EN=0, counters 0. Release, no inputs for 10 cycles → all EN=1, FLUSH=0, STALL_COUNT=0, FLUSH_COUNT=0.
- LU_HAZ_SIG=1 for 1 cycle → that cycle: PC_EN=0, IF_ID_EN=0, ID_EX_FLUSH=1, EX_MEM_EN=1. Next cycle all EN=1. STALL_COUNT=1.
- BRANCH_TAKEN=1 with LU_HAZ_SIG=1 and INSTR_MEM_BUSY=1, then INSTR_MEM_BUSY held 3 more cycles, then low:
  - branch cycle: IF_ID_FLUSH=ID_EX_FLUSH=1, PC_EN=1, FLUSH_PENDING=1 on the next cycle;
  - 4 cycles with IF_ID_FLUSH=1, PC_EN=0, then RUN;
  - FLUSH_COUNT=5, STALL_COUNT=4.
- DATA_MEM_BUSY=1 for 4 cycles together with BRANCH_TAKEN=1 → all EN=0, no flush for 4 cycles. Fifth cycle: branch flush. STALL_COUNT=4, FLUSH_COUNT=1.
- CNT_WIDTH=4, INSTR_MEM_BUSY high 20 cycles → STALL_COUNT saturates at 15. CLEAR_COUNTERS pulse → 0 on the next edge.
- RESET asserted mid-PEND → FLUSH_PENDING=0 immediately. After release, INSTR_MEM_BUSY=0 → no discard cycle, all EN=1.

Source files
------------

// File: rtl/pipeline_stall_controller_if.sv
// Pipeline control bundle: hazard/branch/memory status in, per-stage
// enables, flush controls and performance counters out.
interface pipeline_stall_controller_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 lu_haz_sig;
  logic                 branch_taken;
  logic                 instr_mem_busy;
  logic                 data_mem_busy;
  logic                 clear_counters;
  logic                 pc_en;
  logic                 if_id_en;
  logic                 id_ex_en;
  logic                 ex_mem_en;
  logic                 mem_wb_en;
  logic                 if_id_flush;
  logic                 id_ex_flush;
  logic                 flush_pending;
  logic [CNT_WIDTH-1:0] stall_count;
  logic [CNT_WIDTH-1:0] flush_count;

  // Side that drives the status lines and consumes the controls.
  modport master (
    output lu_haz_sig, branch_taken, instr_mem_busy, data_mem_busy, clear_counters,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_flush, flush_pending, stall_count, flush_count
  );

  // The stall controller itself.
  modport slave (
    input  lu_haz_sig, branch_taken, instr_mem_busy, data_mem_busy, clear_counters,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_flush, flush_pending, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline.
//
// state | meaning
// RUN   | normal operation, no wrong-path fetch outstanding
// PEND  | taken branch hit a busy fetch; the returning word must be discarded
module pipeline_stall_controller #(
  parameter int CNT_WIDTH = 32
) (
  input logic                       clk,
  input logic                       reset,
  pipeline_stall_controller_if.slave bus
);

  typedef enum logic {RUN, PEND} state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 flush_hit;
  logic                 pc_en;
  logic                 if_id_en;
  logic                 id_ex_en;
  logic                 ex_mem_en;
  logic                 mem_wb_en;
  logic                 if_id_flush;
  logic                 id_ex_flush;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;

  // Priority-ordered control decode; the reset term keeps every register
  // frozen while the pipeline is held in reset.
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    state_nxt   = state;
    flush_hit   = 1'b0;
    if (!reset || bus.data_mem_busy) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (bus.branch_taken) begin
      // Hazard is ignored: its consumer in ID is being squashed.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      flush_hit   = 1'b1;
      if (bus.instr_mem_busy) state_nxt = PEND;
    end else if (state == PEND) begin
      // PC already holds the branch target; hold it until the stale word is gone.
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
      flush_hit   = 1'b1;
      if (!bus.instr_mem_busy) state_nxt = RUN;
    end else if (bus.lu_haz_sig) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (bus.instr_mem_busy) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  // State register and saturating performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (bus.clear_counters) begin
        stall_cnt <= '0;
        flush_cnt <= '0;
      end else begin
        if (!pc_en && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
        if (flush_hit && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.pc_en         = pc_en;
  assign bus.if_id_en      = if_id_en;
  assign bus.id_ex_en      = id_ex_en;
  assign bus.ex_mem_en     = ex_mem_en;
  assign bus.mem_wb_en     = mem_wb_en;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_flush   = id_ex_flush;
  assign bus.flush_pending = (state == PEND);
  assign bus.stall_count   = stall_cnt;
  assign bus.flush_count   = flush_cnt;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller. Counter width is 4 so that
// saturation is reachable in a few cycles.
module tb_pipeline_stall_controller;
  localparam int CW = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pipeline_stall_controller_if #(.CNT_WIDTH(CW)) bus ();

  pipeline_stall_controller #(.CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id_flush, id_ex_flush}
  function automatic logic [6:0] ctl();
    return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
            bus.if_id_flush, bus.id_ex_flush};
  endfunction

  // Apply one cycle's inputs at the falling edge; outputs settle 1 time unit later.
  task automatic drive(input logic lu, input logic bt, input logic imb,
                       input logic dmb, input logic clr);
    @(negedge clk);
    bus.lu_haz_sig     = lu;
    bus.branch_taken   = bt;
    bus.instr_mem_busy = imb;
    bus.data_mem_busy  = dmb;
    bus.clear_counters = clr;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.lu_haz_sig = 1'b1; bus.branch_taken = 1'b1; bus.instr_mem_busy = 1'b1;
    bus.data_mem_busy = 1'b0; bus.clear_counters = 1'b0;
    #12;
    checks++;
    if (ctl() !== 7'b0000000 || bus.flush_pending !== 1'b0) begin
      errors++; $display("FAIL reset_ctl got %b/%b want 0000000/0", ctl(), bus.flush_pending);
    end
    checks++;
    if (bus.stall_count !== 4'd0 || bus.flush_count !== 4'd0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", bus.stall_count, bus.flush_count);
    end
    @(negedge clk);
    bus.lu_haz_sig = 1'b0; bus.branch_taken = 1'b0; bus.instr_mem_busy = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 0);
      checks++;
      if (ctl() !== 7'b1111100) begin
        errors++; $display("FAIL idle_ctl cyc %0d got %b want 1111100", i, ctl());
      end
    end
    checks++;
    if (bus.stall_count !== 4'd0 || bus.flush_count !== 4'd0) begin
      errors++; $display("FAIL idle_cnt got %0d/%0d want 0/0", bus.stall_count, bus.flush_count);
    end
  endtask

  task automatic test_load_use;
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    checks++;
    if (ctl() !== 7'b0011101) begin
      errors++; $display("FAIL lu_bubble got %b want 0011101", ctl());
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (ctl() !== 7'b1111100) begin
      errors++; $display("FAIL lu_after got %b want 1111100", ctl());
    end
    checks++;
    if (bus.stall_count !== 4'd1 || bus.flush_count !== 4'd0) begin
      errors++; $display("FAIL lu_cnt got %0d/%0d want 1/0", bus.stall_count, bus.flush_count);
    end
  endtask

  task automatic test_hazard_held;
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0);
      checks++;
      if (ctl() !== 7'b0011101) begin
        errors++; $display("FAIL lu_held cyc %0d got %b want 0011101", i, ctl());
      end
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (bus.stall_count !== 4'd3) begin
      errors++; $display("FAIL lu_held_cnt got %0d want 3", bus.stall_count);
    end
  endtask

  task automatic test_branch_free;
    drive(0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0);
    checks++;
    if (ctl() !== 7'b1111111) begin
      errors++; $display("FAIL br_free got %b want 1111111", ctl());
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (ctl() !== 7'b1111100 || bus.flush_pending !== 1'b0) begin
      errors++; $display("FAIL br_free_after got %b/%b want 1111100/0", ctl(), bus.flush_pending);
    end
    checks++;
    if (bus.stall_count !== 4'd0 || bus.flush_count !== 4'd1) begin
      errors++; $display("FAIL br_free_cnt got %0d/%0d want 0/1", bus.stall_count, bus.flush_count);
    end
  endtask

  task automatic test_branch_busy;
    drive(0, 0, 0, 0, 1);
    drive(1, 1, 1, 0, 0);
    checks++;
    if (ctl() !== 7'b1111111 || bus.flush_pending !== 1'b0) begin
      errors++; $display("FAIL br_busy got %b/%b want 1111111/0", ctl(), bus.flush_pending);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, (i < 3), 0, 0);
      checks++;
      if (ctl() !== 7'b0111110 || bus.flush_pending !== 1'b1) begin
        errors++; $display("FAIL br_pend cyc %0d got %b/%b want 0111110/1", i, ctl(), bus.flush_pending);
      end
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (ctl() !== 7'b1111100 || bus.flush_pending !== 1'b0) begin
      errors++; $display("FAIL br_done got %b/%b want 1111100/0", ctl(), bus.flush_pending);
    end
    checks++;
    if (bus.stall_count !== 4'd4 || bus.flush_count !== 4'd5) begin
      errors++; $display("FAIL br_busy_cnt got %0d/%0d want 4/5", bus.stall_count, bus.flush_count);
    end
  endtask

  task automatic test_dmem_freeze;
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 1, 0);
      checks++;
      if (ctl() !== 7'b0000000) begin
        errors++; $display("FAIL dmem_freeze cyc %0d got %b want 0000000", i, ctl());
      end
    end
    drive(0, 1, 0, 0, 0);
    checks++;
    if (ctl() !== 7'b1111111) begin
      errors++; $display("FAIL dmem_branch got %b want 1111111", ctl());
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (bus.stall_count !== 4'd4 || bus.flush_count !== 4'd1 || bus.flush_pending !== 1'b0) begin
      errors++; $display("FAIL dmem_cnt got %0d/%0d/%b want 4/1/0",
                         bus.stall_count, bus.flush_count, bus.flush_pending);
    end
  endtask

  task automatic test_pend_freeze;
    drive(0, 0, 0, 0, 1);
    drive(0, 1, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 1, 0);
      checks++;
      if (ctl() !== 7'b0000000 || bus.flush_pending !== 1'b1) begin
        errors++; $display("FAIL pend_freeze cyc %0d got %b/%b want 0000000/1", i, ctl(), bus.flush_pending);
      end
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (ctl() !== 7'b0111110 || bus.flush_pending !== 1'b1) begin
      errors++; $display("FAIL pend_discard got %b/%b want 0111110/1", ctl(), bus.flush_pending);
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (bus.stall_count !== 4'd3 || bus.flush_count !== 4'd2 || bus.flush_pending !== 1'b0) begin
      errors++; $display("FAIL pend_freeze_cnt got %0d/%0d/%b want 3/2/0",
                         bus.stall_count, bus.flush_count, bus.flush_pending);
    end
  endtask

  task automatic test_saturate;
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1, 0, 0);
      if (i == 0) begin
        checks++;
        if (ctl() !== 7'b0111110) begin
          errors++; $display("FAIL imem_busy got %b want 0111110", ctl());
        end
      end
      if (i == 15) begin
        checks++;
        if (bus.stall_count !== 4'd15) begin
          errors++; $display("FAIL sat_reach got %0d want 15", bus.stall_count);
        end
      end
    end
    drive(0, 0, 1, 0, 1);
    checks++;
    if (bus.stall_count !== 4'd15 || bus.flush_count !== 4'd0) begin
      errors++; $display("FAIL sat_hold got %0d/%0d want 15/0", bus.stall_count, bus.flush_count);
    end
    drive(0, 0, 1, 0, 0);
    checks++;
    if (bus.stall_count !== 4'd0) begin
      errors++; $display("FAIL clear_override got %0d want 0", bus.stall_count);
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (bus.stall_count !== 4'd1) begin
      errors++; $display("FAIL clear_restart got %0d want 1", bus.stall_count);
    end
  endtask

  task automatic test_reset_in_pend;
    drive(0, 1, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    checks++;
    if (bus.flush_pending !== 1'b1) begin
      errors++; $display("FAIL rst_pend_pre got %b want 1", bus.flush_pending);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.flush_pending !== 1'b0 || ctl() !== 7'b0000000 || bus.stall_count !== 4'd0) begin
      errors++; $display("FAIL rst_pend got %b/%b/%0d want 0/0000000/0",
                         bus.flush_pending, ctl(), bus.stall_count);
    end
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    checks++;
    if (ctl() !== 7'b1111100 || bus.flush_pending !== 1'b0) begin
      errors++; $display("FAIL rst_pend_release got %b/%b want 1111100/0", ctl(), bus.flush_pending);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load_use();
    test_hazard_held();
    test_branch_free();
    test_branch_busy();
    test_dmem_freeze();
    test_pend_freeze();
    test_saturate();
    test_reset_in_pend();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
